uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver. It is the receive end of the link driven by the team's UART transmitter.
- Frame format: 1 start bit (0), in_width data bits LSB first, optional parity bit, 1 stop bit (1).
- RX_IN is oversampled by a runtime prescale. Each bit is decided by a 3-sample majority vote around the bit centre.
- Outputs a parallel word with a one-cycle valid pulse and per-frame error flags. Feeds the downstream register/FIFO layer.

Parameters:
- in_width, 8: number of data bits per frame.
- prescale_width, 6: width of the prescale port and of the edge counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idles high; already synchronised upstream.
- prescale  input  prescale_width  clocks per bit; legal values 8, 16, 32.
- parity_EN  input  1  1 = frame carries a parity bit.
- parity_type  input  1  1 = odd parity, 0 = even parity (same encoding as the transmitter).
- P_DATA  output  in_width  last correctly received data word.
- data_vaild  output  1  one-cycle pulse: P_DATA updated with a good frame.
- parity_error  output  1  one-cycle pulse: parity mismatch in the completed frame.
- stop_error  output  1  one-cycle pulse: stop bit sampled as 0.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst=0, all outputs are 0 (including P_DATA), state is IDLE, and all counters are 0.
  - Reset asserted mid-frame aborts the frame immediately. No pulse is generated for the aborted frame.
- Configuration: prescale, parity_EN and parity_type are captured in the cycle the start bit is detected and held for the whole frame. Changing them mid-frame has no effect on the current frame.
- Counters:
  - edge_cnt counts 0..prescale-1 within each bit period.
  - bit_cnt counts bits within the data state.
  - edge_cnt wraps to 0 at prescale-1 and bit_cnt advances on the wrap.
- Sampling:
  - RX_IN is sampled at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
  - The bit value is the majority of the 3 samples and is valid from edge_cnt = prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when RX_IN=0 is sampled. That cycle is edge 0 of the start bit.
  - START: if the majority value is 1 (glitch), go to IDLE at edge prescale/2+2 with no error flags. Otherwise go to DATA at edge prescale-1.
  - DATA: shift the majority bit into the shift register LSB first. After in_width bit periods go to PARITY if parity_EN=1, else to STOP.
  - PARITY: compare the majority bit with the expected parity. Expected parity is ^data for even, ~^data for odd. Store the mismatch result. Go to STOP at edge prescale-1.
  - STOP:
    - At edge prescale-1, evaluate the stop bit and go to IDLE.
    - If stop=1 and there is no parity mismatch: load P_DATA from the shift register and pulse data_vaild.
    - Otherwise: pulse parity_error and/or stop_error. P_DATA keeps its previous value and data_vaild stays 0.
- Output timing: all outputs are registered. The pulses rise (10 + parity_EN) * prescale... precisely (in_width + 2 + parity_EN) * prescale clock edges after the start-detect edge, and last exactly one cycle.
- Back-to-back frames: a new start bit is detectable in the cycle after the return to IDLE. The one-cycle phase slip this introduces is absorbed by centre sampling.
- Line held low after a stop error: treated as a new start bit in the next cycle.
- Illegal prescale values: behaviour is undefined. No protection is required.

Decomposition:
- Shared package (uart_pkg):
  - state encoding enum for the five states.
  - PARITY_ODD = 1 and PARITY_EVEN = 0 constants, shared with the transmitter.
  - legal prescale constants 8, 16, 32.
- Sub-module uart_rx_sampler:
  - takes edge_cnt, prescale and RX_IN.
  - holds the 3 sample registers.
  - outputs sampled_bit and sample_done.
- The FSM, counters, shift register and checks stay in uart_rx.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then RX_IN=1 for 100 cycles -> all outputs 0, no pulses.
- Odd parity, prescale=8, frame 0x43 with parity bit 0 -> P_DATA=0x43, data_vaild high for 1 cycle 88 clocks after start detect, both error flags 0.
- Back-to-back, prescale=16, even parity: 0x47 (parity 0) then 0xC6 (parity 0) with no idle gap -> two data_vaild pulses, P_DATA=0x47 then 0xC6.
- Error frames:
  - parity_EN=1, odd, 0x47 sent with parity bit 0 -> parity_error pulse, data_vaild 0, P_DATA unchanged.
  - Stop bit forced 0 -> stop_error pulse.
- Glitch and no-parity cases:
  - 2-clock low glitch at prescale=8 -> return to IDLE, no pulses.
  - parity_EN=0, 0x47 -> data_vaild after 80 clocks.
- Mid-frame reset: rst=0 during DATA bit 3, then a full clean frame 0xA5 -> only one data_vaild pulse, P_DATA=0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity
// encoding and legal prescale values (common with the transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// 3-point majority sampler around the bit centre.
// Ports: clk, rst (async active-low), i_edge_cnt, i_prescale, i_rx
//        -> o_sampled_bit (majority), o_sample_done (majority valid).
module uart_rx_sampler #(
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [prescale_width-1:0] i_edge_cnt,
    input  logic [prescale_width-1:0] i_prescale,
    input  logic                      i_rx,
    output logic                      o_sampled_bit,
    output logic                      o_sample_done
);

    localparam logic [prescale_width-1:0] C_ONE = 1;
    localparam logic [prescale_width-1:0] C_TWO = 2;

    logic [prescale_width-1:0] w_half;
    logic [2:0]                r_smp;

    assign w_half = i_prescale >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp <= '0;
        end else begin
            if (i_edge_cnt == w_half - C_ONE) r_smp[0] <= i_rx;
            if (i_edge_cnt == w_half)         r_smp[1] <= i_rx;
            if (i_edge_cnt == w_half + C_ONE) r_smp[2] <= i_rx;
        end
    end

    assign o_sampled_bit = (r_smp[0] & r_smp[1]) |
                           (r_smp[0] & r_smp[2]) |
                           (r_smp[1] & r_smp[2]);

    // Last sample lands at half+1, so the vote is stable from half+2
    // until the next bit's first sample.
    assign o_sample_done = (i_edge_cnt == w_half + C_TWO);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with oversampling.
// Ports: clk, rst (async active-low), RX_IN, prescale, parity_EN,
//        parity_type -> P_DATA, data_vaild, parity_error, stop_error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int in_width       = 8,
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic [prescale_width-1:0] prescale,
    input  logic                      parity_EN,
    input  logic                      parity_type,
    output logic [in_width-1:0]       P_DATA,
    output logic                      data_vaild,
    output logic                      parity_error,
    output logic                      stop_error
);

    localparam int BW = (in_width > 1) ? $clog2(in_width) : 1;
    localparam logic [prescale_width-1:0] C_ONE = 1;
    localparam logic [BW-1:0] C_LAST_BIT = BW'(in_width - 1);

    rx_state_t                 r_state;
    logic [prescale_width-1:0] r_edge_cnt;
    logic [prescale_width-1:0] r_prescale;
    logic [BW-1:0]             r_bit_cnt;
    logic                      r_pen;
    logic                      r_ptype;
    logic                      r_par_err;
    logic [in_width-1:0]       r_shift;

    logic w_bit;
    logic w_done;
    logic w_last_edge;
    logic w_exp_par;

    assign w_last_edge = (r_edge_cnt == r_prescale - C_ONE);
    assign w_exp_par   = (r_ptype == PARITY_ODD) ? ~^r_shift : ^r_shift;

    uart_rx_sampler #(
        .prescale_width(prescale_width)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .i_edge_cnt   (r_edge_cnt),
        .i_prescale   (r_prescale),
        .i_rx         (RX_IN),
        .o_sampled_bit(w_bit),
        .o_sample_done(w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_edge_cnt   <= '0;
            r_prescale   <= '0;
            r_bit_cnt    <= '0;
            r_pen        <= 1'b0;
            r_ptype      <= 1'b0;
            r_par_err    <= 1'b0;
            r_shift      <= '0;
            P_DATA       <= '0;
            data_vaild   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_vaild   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            if (r_state != ST_IDLE) begin
                r_edge_cnt <= w_last_edge ? '0 : r_edge_cnt + C_ONE;
            end

            unique case (r_state)
                ST_IDLE: begin
                    // The detect cycle counts as edge 0, so the
                    // first START cycle carries edge_cnt = 0.
                    if (!RX_IN) begin
                        r_state    <= ST_START;
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_prescale <= prescale;
                        r_pen      <= parity_EN;
                        r_ptype    <= parity_type;
                        r_par_err  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_done && w_bit) begin
                        r_state    <= ST_IDLE;
                        r_edge_cnt <= '0;
                    end else if (w_last_edge) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_last_edge) begin
                        r_shift <= {w_bit, r_shift[in_width-1:1]};
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_pen ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_last_edge) begin
                        r_par_err <= (w_bit != w_exp_par);
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_last_edge) begin
                        r_state <= ST_IDLE;
                        if (w_bit && !r_par_err) begin
                            P_DATA     <= r_shift;
                            data_vaild <= 1'b1;
                        end else begin
                            parity_error <= r_par_err;
                            stop_error   <= ~w_bit;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed and random frames, expected
// pulses queued by the driver and popped by an output monitor.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       parity_EN = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] P_DATA;
    logic       data_vaild;
    logic       parity_error;
    logic       stop_error;

    typedef struct {
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] pd;
        longint     cyc;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc = 0;
    longint     prev_end = 0;
    logic [7:0] last_good = 8'h00;
    int         prev_gap = 10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .in_width      (8),
        .prescale_width(6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .parity_EN   (parity_EN),
        .parity_type (parity_type),
        .P_DATA      (P_DATA),
        .data_vaild  (data_vaild),
        .parity_error(parity_error),
        .stop_error  (stop_error)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && (data_vaild || parity_error || stop_error)) begin
            if (q.size() == 0) begin
                check("pulse_with_empty_queue",
                      {data_vaild, parity_error, stop_error}, 0);
            end else begin
                e = q.pop_front();
                check("data_vaild", data_vaild, e.v);
                check("parity_error", parity_error, e.pe);
                check("stop_error", stop_error, e.se);
                check("P_DATA", P_DATA, e.pd);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_frame(input int p, input bit pen, input bit ptype,
                              input logic [7:0] d, input bit pflip,
                              input bit stopb, input int gap);
        exp_t   e;
        bit     par;
        bit     bits[$];
        longint det;
        repeat (gap) @(negedge clk);
        par = (($countones(d) % 2) == 1) ^ ptype;
        if (pflip) par = !par;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(par);
        bits.push_back(stopb);
        prescale    = 6'(p);
        parity_EN   = pen;
        parity_type = ptype;
        det   = (cyc + 1 > prev_end + 1) ? cyc + 1 : prev_end + 1;
        e.v   = stopb && !(pen && pflip);
        e.pe  = pen && pflip;
        e.se  = !stopb;
        if (e.v) last_good = d;
        e.pd  = last_good;
        e.cyc = det + longint'(bits.size() * p);
        prev_end = e.cyc;
        q.push_back(e);
        for (int i = 0; i < bits.size(); i++) begin
            RX_IN = bits[i];
            repeat (p) @(negedge clk);
            if (i == 0) begin
                prescale    = ($urandom_range(0, 1) == 0) ? 6'd16 : 6'd32;
                parity_EN   = 1'($urandom_range(0, 1));
                parity_type = 1'($urandom_range(0, 1));
            end
        end
        RX_IN = 1'b1;
        prev_gap = gap;
    endtask

    task automatic glitch(input int p, input int len);
        while (cyc <= prev_end + 1) @(negedge clk);
        prescale = 6'(p);
        RX_IN = 1'b0;
        repeat (len) @(negedge clk);
        RX_IN = 1'b1;
        repeat (2 * p) @(negedge clk);
        prev_gap = 10;
    endtask

    task automatic reset_mid_frame();
        while (cyc <= prev_end + 1) @(negedge clk);
        prescale    = 6'd16;
        parity_EN   = 1'b0;
        parity_type = PARITY_EVEN;
        RX_IN = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX_IN = 1'($urandom_range(0, 1));
            repeat (16) @(negedge clk);
        end
        RX_IN = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_P_DATA", P_DATA, 8'h00);
        check("rst_valid", data_vaild, 1'b0);
        check("rst_perr", parity_error, 1'b0);
        check("rst_serr", stop_error, 1'b0);
        rst = 1'b1;
        last_good = 8'h00;
        prev_end = 0;
        repeat (40) @(negedge clk);
        prev_gap = 10;
    endtask

    initial begin : driver
        int  sel;
        int  p;
        int  r;
        int  gap;
        bit  pen;
        bit  ptype;
        int  guard;
        repeat (2) @(negedge clk);
        check("reset_P_DATA", P_DATA, 8'h00);
        check("reset_valid", data_vaild, 1'b0);
        check("reset_perr", parity_error, 1'b0);
        check("reset_serr", stop_error, 1'b0);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_P_DATA", P_DATA, 8'h00);

        send_frame(8, 1'b1, PARITY_ODD, 8'h43, 1'b0, 1'b1, 2);
        send_frame(16, 1'b1, PARITY_EVEN, 8'h47, 1'b0, 1'b1, 4);
        send_frame(16, 1'b1, PARITY_EVEN, 8'hC6, 1'b0, 1'b1, 0);
        send_frame(16, 1'b1, PARITY_ODD, 8'h47, 1'b1, 1'b1, 4);
        send_frame(8, 1'b0, PARITY_EVEN, 8'h3C, 1'b0, 1'b0, 3);
        glitch(8, 2);
        send_frame(8, 1'b0, PARITY_EVEN, 8'h47, 1'b0, 1'b1, 3);
        reset_mid_frame();
        send_frame(16, 1'b0, PARITY_EVEN, 8'hA5, 1'b0, 1'b1, 2);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 2);
            p = (sel == 0) ? PRESCALE_8 :
                (sel == 1) ? PRESCALE_16 : PRESCALE_32;
            r = $urandom_range(0, 5);
            pen = 1'($urandom_range(0, 1));
            ptype = 1'($urandom_range(0, 1));
            gap = (prev_gap >= 2) ? $urandom_range(0, 4)
                                  : $urandom_range(2, 4);
            send_frame(p, pen, ptype, 8'($urandom), pen && (r == 0),
                       r != 1, gap);
        end

        guard = 0;
        while (q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", q.size(), 0);
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
